// File: rtl/main_memory.sv
// Word-addressable 1 KiB memory that returns the whole 4-word block holding the
// addressed word. Reads are combinational; writes and reset-initialisation happen on the clock edge.
module main_memory #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         read_write,
    input  logic [9:0]   Address,
    input  logic [31:0]  write_data,
    output logic [127:0] read_data
);

    logic [31:0] mem [DEPTH_WORDS];

    logic [7:0] word_idx;
    logic [5:0] block_idx;
    logic       unused_byte_offset;

    assign word_idx           = Address[9:2];
    assign block_idx          = Address[9:4];
    assign unused_byte_offset = ^Address[1:0];

    // Reset preloads every word with its own index and overrides any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'(i);
            end
        end else if (read_write) begin
            mem[word_idx] <= write_data;
        end
    end

    always_comb begin
        read_data = '0;
        for (int k = 0; k < 4; k++) begin
            read_data[32*k +: 32] = mem[{block_idx, 2'(k)}];
        end
    end

endmodule

// File: tb/tb_main_memory.sv
// Directed self-checking bench for main_memory: reset image, block reads, writes,
// reset priority, back-to-back writes, boundary words and mid-cycle input changes.
module tb_main_memory;

    logic         clk;
    logic         reset;
    logic         read_write;
    logic [9:0]   Address;
    logic [31:0]  write_data;
    logic [127:0] read_data;

    int pass_cnt  = 0;
    int total_cnt = 0;

    main_memory #(.DEPTH_WORDS(256)) dut (
        .clk       (clk),
        .reset     (reset),
        .read_write(read_write),
        .Address   (Address),
        .write_data(write_data),
        .read_data (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before limit");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset      = 1'b1;
        read_write = 1'b0;
        tick();
        reset      = 1'b0;
    endtask

    task automatic test_reset;
        logic [127:0] exp;
        apply_reset();
        Address = 10'h000;
        #1;
        exp = 128'h00000003_00000002_00000001_00000000;
        total_cnt++;
        if (read_data !== exp) $display("FAIL reset_block0: got %h expected %h", read_data, exp);
        else pass_cnt++;
        Address = 10'h3F7;
        #1;
        exp = 128'h000000FF_000000FE_000000FD_000000FC;
        total_cnt++;
        if (read_data !== exp) $display("FAIL reset_block63: got %h expected %h", read_data, exp);
        else pass_cnt++;
    endtask

    task automatic test_write;
        logic [127:0] exp;
        read_write = 1'b1;
        Address    = 10'h018;
        write_data = 32'hDEADBEEF;
        #1;
        total_cnt++;
        if (read_data[95:64] !== 32'h00000006)
            $display("FAIL write_prewrite: got %h expected %h", read_data[95:64], 32'h00000006);
        else pass_cnt++;
        tick();
        read_write = 1'b0;
        Address    = 10'h010;
        #1;
        exp = 128'h00000007_DEADBEEF_00000005_00000004;
        total_cnt++;
        if (read_data !== exp) $display("FAIL write_block1: got %h expected %h", read_data, exp);
        else pass_cnt++;
    endtask

    task automatic test_byte_offset;
        read_write = 1'b1;
        Address    = 10'h023;
        write_data = 32'hAAAA5555;
        tick();
        read_write = 1'b0;
        Address    = 10'h020;
        #1;
        total_cnt++;
        if (read_data[31:0] !== 32'hAAAA5555)
            $display("FAIL byte_offset_word8: got %h expected %h", read_data[31:0], 32'hAAAA5555);
        else pass_cnt++;
        total_cnt++;
        if (read_data[63:32] !== 32'h00000009)
            $display("FAIL byte_offset_word9: got %h expected %h", read_data[63:32], 32'h00000009);
        else pass_cnt++;
    endtask

    task automatic test_reset_priority;
        logic [127:0] exp;
        reset      = 1'b1;
        read_write = 1'b1;
        Address    = 10'h000;
        write_data = 32'h12345678;
        tick();
        reset      = 1'b0;
        read_write = 1'b0;
        #1;
        total_cnt++;
        if (read_data[31:0] !== 32'h00000000)
            $display("FAIL reset_priority: got %h expected %h", read_data[31:0], 32'h00000000);
        else pass_cnt++;
        Address = 10'h010;
        #1;
        exp = 128'h00000007_00000006_00000005_00000004;
        total_cnt++;
        if (read_data !== exp) $display("FAIL reset_restores: got %h expected %h", read_data, exp);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [127:0] exp;
        read_write = 1'b1;
        Address    = 10'h100;
        write_data = 32'h11111111;
        tick();
        total_cnt++;
        if (read_data[31:0] !== 32'h11111111)
            $display("FAIL b2b_immediate: got %h expected %h", read_data[31:0], 32'h11111111);
        else pass_cnt++;
        Address    = 10'h104;
        write_data = 32'h22222222;
        tick();
        Address    = 10'h100;
        write_data = 32'h33333333;
        tick();
        read_write = 1'b0;
        #1;
        exp = 128'h00000043_00000042_22222222_33333333;
        total_cnt++;
        if (read_data !== exp) $display("FAIL b2b_last_wins: got %h expected %h", read_data, exp);
        else pass_cnt++;
    endtask

    task automatic test_boundary;
        logic [127:0] exp;
        read_write = 1'b1;
        Address    = 10'h3FC;
        write_data = 32'hCAFEF00D;
        tick();
        Address    = 10'h000;
        write_data = 32'h0BADF00D;
        tick();
        read_write = 1'b0;
        Address    = 10'h3F0;
        #1;
        exp = 128'hCAFEF00D_000000FE_000000FD_000000FC;
        total_cnt++;
        if (read_data !== exp) $display("FAIL boundary_word255: got %h expected %h", read_data, exp);
        else pass_cnt++;
        Address = 10'h000;
        #1;
        exp = 128'h00000003_00000002_00000001_0BADF00D;
        total_cnt++;
        if (read_data !== exp) $display("FAIL boundary_word0: got %h expected %h", read_data, exp);
        else pass_cnt++;
    endtask

    task automatic test_midcycle;
        logic [127:0] exp;
        read_write = 1'b1;
        Address    = 10'h200;
        write_data = 32'h99999999;
        #2;
        Address    = 10'h204;
        write_data = 32'h55555555;
        tick();
        read_write = 1'b0;
        Address    = 10'h200;
        #1;
        exp = 128'h00000083_00000082_55555555_00000080;
        total_cnt++;
        if (read_data !== exp) $display("FAIL midcycle_sampled: got %h expected %h", read_data, exp);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (read_data !== exp) $display("FAIL midcycle_reset_wait: got %h expected %h", read_data, exp);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        exp = 128'h00000083_00000082_00000081_00000080;
        total_cnt++;
        if (read_data !== exp) $display("FAIL midcycle_reset_edge: got %h expected %h", read_data, exp);
        else pass_cnt++;
    endtask

    task automatic test_read_sweep;
        logic [127:0] exp;
        apply_reset();
        read_write = 1'b0;
        for (int k = 0; k < 64; k++) begin
            Address    = {6'(k), 2'(k % 4), 2'(k % 3)};
            write_data = $urandom;
            tick();
            exp = {32'(4*k + 3), 32'(4*k + 2), 32'(4*k + 1), 32'(4*k)};
            total_cnt++;
            if (read_data !== exp) $display("FAIL sweep_block%0d: got %h expected %h", k, read_data, exp);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset      = 1'b0;
        read_write = 1'b0;
        Address    = 10'h000;
        write_data = 32'h0;
        tick();
        test_reset();
        test_write();
        test_byte_offset();
        test_reset_priority();
        test_back_to_back();
        test_boundary();
        test_midcycle();
        test_read_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 The block SHALL have one parameter: DEPTH_WORDS, default 256, number of 32-bit words (fixed by the 10-bit byte address).
REQ-002 The block SHALL have port clk, input, 1 bit, sole clock, rising-edge active.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port read_write, input, 1 bit, 0 = read, 1 = write word.
REQ-005 The block SHALL have port Address, input, 10 bits, byte address: [9:4] block, [3:2] word-in-block, [1:0] byte offset.
REQ-006 The block SHALL have port write_data, input, 32 bits, word to store on write.
REQ-007 The block SHALL have port read_data, output, 128 bits, full 4-word block containing Address.
REQ-008 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.

Function
REQ-009 Storage SHALL be 256 words x 32 bits (1 KiB), word index = Address[9:2], organized as 64 blocks of 4 words.
REQ-010 Address[1:0] SHALL be ignored; all accesses are word-aligned.
REQ-011 read_data SHALL be combinational (zero-latency) from the current array contents, independent of read_write.
REQ-012 read_data[32k+31:32k] SHALL equal word {Address[9:4], k} for k = 0..3; word 0 occupies bits [31:0], word 3 bits [127:96].
REQ-013 When read_write = 1 and reset = 0, write_data SHALL be stored into word Address[9:2] on the rising clk edge; the other three words of the block SHALL be unchanged.
REQ-014 When read_write = 0, array contents SHALL NOT change.
REQ-015 During the write cycle read_data SHALL show pre-write contents; the new word SHALL appear on read_data immediately after the edge (no extra latency).
REQ-016 Back-to-back writes on consecutive cycles SHALL each take effect at their own edge; last write to a word wins.
REQ-017 Address and write_data changes between edges SHALL have no effect on storage; only values sampled at the rising edge matter.
REQ-018 Writes to word 255 and word 0 SHALL behave identically to any other word; there is no wrap or out-of-range condition.

Reset
REQ-019 On a rising clk edge with reset = 1, every word i (0..255) SHALL be loaded with the 32-bit value i (zero-extended word index).
REQ-020 A write requested in a cycle where reset = 1 SHALL be discarded; reset has priority.
REQ-021 Reset asserted between edges SHALL have no effect until the next rising edge; read_data remains combinational throughout reset.
REQ-022 Array contents before the first reset SHALL be unspecified; benches SHALL apply reset for at least one edge before checking data.

Verification
REQ-023 Reset one cycle, read_write = 0, Address = 10'h000 -> read_data = 128'h00000003_00000002_00000001_00000000.
REQ-024 After reset, Address = 10'h3F7 (block 63, word 1) -> read_data = 128'h000000FF_000000FE_000000FD_000000FC.
REQ-025 Write read_write = 1, Address = 10'h018, write_data = 32'hDEADBEEF, one edge; then read Address = 10'h010 -> read_data = 128'h00000007_DEADBEEF_00000005_00000004; before the edge read_data[95:64] = 32'h00000006.
REQ-026 Write 32'hAAAA5555 with Address = 10'h023 (byte offset 3) -> word 8 updated; read Address = 10'h020 -> read_data[31:0] = 32'hAAAA5555.
REQ-027 Assert reset together with read_write = 1, Address = 10'h000, write_data = 32'h12345678 -> after the edge read_data[31:0] = 32'h00000000.
REQ-028 Hold read_write = 0, sweep Address through all 64 blocks over several edges -> contents never change; each block k returns words 4k..4k+3.
